// File: rtl/vpad_event_agg_pkg.sv
// Shared sizing helpers and event-field constants for the virtual pad event aggregator.
// Latency: none (compile-time definitions only).
// Backpressure: not applicable.
//
// Contents: TOTAL / IDXW / count-width helpers, DIR_PRESS / DIR_RELEASE encodings,
// event field offsets ({dir, index}) and the saturation limit of the drop counter.
package vpad_event_agg_pkg;

  localparam logic        DIR_PRESS   = 1'b1;
  localparam logic        DIR_RELEASE = 1'b0;
  localparam int          EVT_IDX_LSB = 0;
  localparam logic [15:0] DROPPED_MAX = 16'hFFFF;

  function automatic int calc_total(input int num_boards, input int pad_width);
    return num_boards * pad_width;
  endfunction

  // A single-button build still needs a 1-bit index field.
  function automatic int calc_idxw(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Direction bit sits directly above the index field.
  function automatic int evt_dir_pos(input int idxw);
    return idxw;
  endfunction

  function automatic int calc_cntw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vpad_event_agg_fifo.sv
// vpad_evt_fifo: small event queue with head read straight from the storage flops.
// Latency: a push is visible at the head one edge later when the queue was empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop on empty ignored.
//
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   push, push_data     enqueue request and payload
//   full                no free entry this cycle
//   pop                 dequeue request (acts only when valid)
//   valid, head         head entry present / head payload (zero when empty)
//   count               entries currently held
module vpad_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt == CNTW'(DEPTH));
    valid   = (cnt != '0);
    do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    do_push = push && (!full || do_pop);
    head    = valid ? mem[rd_ptr] : '0;
    count   = cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vpad_event_agg.sv
// vpad_event_agg: merges NUM_BOARDS pad banks into one debounced vector and queues press/release events.
// Latency: pad_in -> val 2+DB_CYCLES edges; pad_in -> evt_valid 3+DB_CYCLES edges from an empty queue.
// Backpressure: evt_valid/evt_ready; a full queue parks edges in pending masks, only a repeat edge drops.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   pad_in         raw asynchronous pad levels {board N-1 .. board 0}
//   val            debounced pad levels
//   evt_valid/evt_ready/evt_data   event stream, evt_data = {dir, index}, dir 1 = press
//   evt_count      entries queued
//   dropped        saturating count of lost edges
// Build option: VPAD_EVENT_AGG_RELEASE_EN enables release events (default build: presses only).
module vpad_event_agg
  import vpad_event_agg_pkg::*;
#(
  parameter int NUM_BOARDS = 4,
  parameter int PAD_WIDTH  = 4,
  parameter int DB_CYCLES  = 1000,
  parameter int FIFO_DEPTH = 8,
  localparam int TOTAL = calc_total(NUM_BOARDS, PAD_WIDTH),
  localparam int IDXW  = calc_idxw(TOTAL),
  localparam int EVTW  = IDXW + 1,
  localparam int CNTW  = calc_cntw(FIFO_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TOTAL-1:0] pad_in,
  output logic [TOTAL-1:0] val,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVTW-1:0]  evt_data,
  output logic [CNTW-1:0]  evt_count,
  output logic [15:0]      dropped
);

  localparam int DIR_POS = evt_dir_pos(IDXW);

  logic [TOTAL-1:0] s1;
  logic [TOTAL-1:0] s2;
  logic [TOTAL-1:0] val_nxt;
  logic [TOTAL-1:0] rise;
  logic [TOTAL-1:0] press_pend;
  logic [TOTAL-1:0] press_nxt;
  logic [TOTAL-1:0] press_clr;
  logic [TOTAL-1:0] pick_onehot;
  logic [IDXW-1:0]  pick_idx;
  logic             sel_press;
  logic             any_pend;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic [EVTW-1:0]  push_data;
  logic [16:0]      n_drop;
  logic [16:0]      drop_sum;
  logic [15:0]      dropped_nxt;
`ifdef VPAD_EVENT_AGG_RELEASE_EN
  logic [TOTAL-1:0] fall;
  logic [TOTAL-1:0] rel_pend;
  logic [TOTAL-1:0] rel_nxt;
  logic [TOTAL-1:0] rel_clr;
`endif

  function automatic logic [IDXW-1:0] lowest_idx(input logic [TOTAL-1:0] m);
    lowest_idx = '0;
    for (int i = TOTAL - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDXW'(i);
    end
  endfunction

  // Two-flop synchroniser; pad_in is asynchronous to clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
    end
  end

  generate
    if (DB_CYCLES == 0) begin : g_bypass
      assign val_nxt = s2;
    end else begin : g_db
      localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
      logic [DBW-1:0]   cnt [TOTAL];
      logic [TOTAL-1:0] hit;

      // hit: this is the DB_CYCLES-th consecutive edge on which s2 differs from val.
      always_comb begin
        hit = '0;
        for (int i = 0; i < TOTAL; i++) begin
          hit[i] = (s2[i] != val[i]) && (cnt[i] == DBW'(DB_CYCLES - 1));
        end
      end

      // hit implies s2 != val, so flipping the bit is the same as taking s2.
      assign val_nxt = val ^ hit;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < TOTAL; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < TOTAL; i++) begin
            if ((s2[i] == val[i]) || hit[i]) cnt[i] <= '0;
            else                             cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Edge capture and single-event-per-cycle scheduler: presses outrank releases,
  // lowest index first. A set landing on a bit that is being scheduled this same
  // cycle keeps the bit pending, so the new edge is not lost.
  always_comb begin
    pop         = evt_valid && evt_ready;
    rise        = val_nxt & ~val;
    sel_press   = |press_pend;
    any_pend    = sel_press;
    pick_idx    = lowest_idx(press_pend);
    press_clr   = '0;
    n_drop      = '0;
`ifdef VPAD_EVENT_AGG_RELEASE_EN
    fall        = val & ~val_nxt;
    rel_clr     = '0;
    if (!sel_press) begin
      any_pend  = |rel_pend;
      pick_idx  = lowest_idx(rel_pend);
    end
`endif
    push        = any_pend && (!fifo_full || pop);
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
    if (push && sel_press) press_clr = pick_onehot;
`ifdef VPAD_EVENT_AGG_RELEASE_EN
    if (push && !sel_press) rel_clr = pick_onehot;
    n_drop      = 17'($countones(rise & press_pend & ~press_clr))
                + 17'($countones(fall & rel_pend & ~rel_clr));
    rel_nxt     = (rel_pend & ~rel_clr) | fall;
`endif
    // Without release events a repeat press on a still-pending bit is
    // indistinguishable to the consumer, so it merges instead of dropping.
    press_nxt   = (press_pend & ~press_clr) | rise;
    push_data   = '0;
    push_data[DIR_POS] = sel_press ? DIR_PRESS : DIR_RELEASE;
    push_data[DIR_POS-1:EVT_IDX_LSB] = pick_idx;
    drop_sum    = {1'b0, dropped} + n_drop;
    dropped_nxt = drop_sum[16] ? DROPPED_MAX : drop_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val        <= '0;
      press_pend <= '0;
      dropped    <= '0;
    end else begin
      val        <= val_nxt;
      press_pend <= press_nxt;
      dropped    <= dropped_nxt;
    end
  end

`ifdef VPAD_EVENT_AGG_RELEASE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rel_pend <= '0;
    else       rel_pend <= rel_nxt;
  end
`endif

  vpad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVTW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (evt_ready),
    .valid     (evt_valid),
    .head      (evt_data),
    .count     (evt_count)
  );

endmodule
